// File: rtl/dac_frame_scheduler.sv
// Per-frame DAC sample scheduler: on every synchronized lrck rise it polls each
// enabled source in index order, sums the stereo samples and commits them saturated.
module dac_frame_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lrck,
  input  logic [NUM_SRC-1:0]     src_en,
  output logic [NUM_SRC-1:0]     req,
  input  logic [NUM_SRC-1:0]     ack,
  input  logic [16*NUM_SRC-1:0]  src_left,
  input  logic [16*NUM_SRC-1:0]  src_right,
  output logic [15:0]            left,
  output logic [15:0]            right,
  output logic                   frame_done,
  output logic                   busy,
  output logic [NUM_SRC-1:0]     underrun,
  output logic                   overrun,
  input  logic                   underrun_clr
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int ACC_W = 16 + IDX_W;
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [TMR_W-1:0]        TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32'sd32768);
  localparam logic [NUM_SRC-1:0]      ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_lrck_meta;
  logic                     r_lrck_sync;
  logic                     r_lrck_hist;
  logic [IDX_W-1:0]         r_idx;
  logic [TMR_W-1:0]         r_timer;
  logic signed [ACC_W-1:0]  r_acc_l;
  logic signed [ACC_W-1:0]  r_acc_r;
  logic [NUM_SRC-1:0]       r_req;
  logic [15:0]              r_left;
  logic [15:0]              r_right;
  logic                     r_frame_done;
  logic                     r_busy;
  logic [NUM_SRC-1:0]       r_underrun;
  logic                     r_overrun;

  logic                     w_tick;
  logic                     w_start;
  logic                     w_grant;
  logic                     w_ack;
  logic                     w_timeout;
  logic                     w_tmr_inc;
  logic                     w_adv;
  logic                     w_commit;
  logic [15:0]              w_smp_l;
  logic [15:0]              w_smp_r;
  logic signed [ACC_W-1:0]  w_ext_l;
  logic signed [ACC_W-1:0]  w_ext_r;
  logic [NUM_SRC-1:0]       w_sel;

  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
    logic [15:0] res;
    if (a > SAT_MAX) begin
      res = 16'h7FFF;
    end else if (a < SAT_MIN) begin
      res = 16'h8000;
    end else begin
      res = a[15:0];
    end
    return res;
  endfunction

  assign w_tick  = r_lrck_sync & ~r_lrck_hist;
  assign w_sel   = ONE_HOT0 << r_idx;
  assign w_smp_l = src_left[{r_idx, 4'b0000} +: 16];
  assign w_smp_r = src_right[{r_idx, 4'b0000} +: 16];
  assign w_ext_l = {{IDX_W{w_smp_l[15]}}, w_smp_l};
  assign w_ext_r = {{IDX_W{w_smp_r[15]}}, w_smp_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lrck_meta <= 1'b0;
      r_lrck_sync <= 1'b0;
      r_lrck_hist <= 1'b0;
    end else begin
      r_lrck_meta <= lrck;
      r_lrck_sync <= r_lrck_meta;
      r_lrck_hist <= r_lrck_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_tick ? S_GRANT : S_IDLE;
      S_GRANT:  w_state_nxt = src_en[r_idx] ? S_WAIT : S_NEXT;
      S_WAIT:   w_state_nxt = (ack[r_idx] || (r_timer == TMR_MAX)) ? S_NEXT : S_WAIT;
      S_NEXT:   w_state_nxt = (r_idx == LAST_IDX) ? S_COMMIT : S_GRANT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // An ack arriving on the timeout cycle still counts; the timeout only fires without it.
  always_comb begin
    w_start   = 1'b0;
    w_grant   = 1'b0;
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    w_tmr_inc = 1'b0;
    w_adv     = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE:   w_start = w_tick;
      S_GRANT:  w_grant = src_en[r_idx];
      S_WAIT: begin
        w_ack     = ack[r_idx];
        w_timeout = ~ack[r_idx] & (r_timer == TMR_MAX);
        w_tmr_inc = ~ack[r_idx] & (r_timer != TMR_MAX);
      end
      S_NEXT:   w_adv    = (r_idx != LAST_IDX);
      S_COMMIT: w_commit = 1'b1;
      default: begin
        w_start  = 1'b0;
        w_commit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= {IDX_W{1'b0}};
      r_timer <= {TMR_W{1'b0}};
      r_acc_l <= {ACC_W{1'b0}};
      r_acc_r <= {ACC_W{1'b0}};
      r_req   <= {NUM_SRC{1'b0}};
    end else begin
      if (w_start) begin
        r_idx   <= {IDX_W{1'b0}};
        r_acc_l <= {ACC_W{1'b0}};
        r_acc_r <= {ACC_W{1'b0}};
      end else if (w_adv) begin
        r_idx <= r_idx + IDX_W'(1);
      end else if (w_ack) begin
        r_acc_l <= r_acc_l + w_ext_l;
        r_acc_r <= r_acc_r + w_ext_r;
      end
      if (w_grant) begin
        r_timer <= {TMR_W{1'b0}};
        r_req   <= w_sel;
      end else begin
        if (w_tmr_inc) begin
          r_timer <= r_timer + TMR_W'(1);
        end
        if (w_ack || w_timeout) begin
          r_req <= {NUM_SRC{1'b0}};
        end
      end
    end
  end

  // Sticky flags: a set in the same cycle as underrun_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_left       <= 16'h0000;
      r_right      <= 16'h0000;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_underrun   <= {NUM_SRC{1'b0}};
      r_overrun    <= 1'b0;
    end else begin
      if (w_commit) begin
        r_left  <= sat16(r_acc_l);
        r_right <= sat16(r_acc_r);
      end
      r_frame_done <= w_commit;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_underrun   <= (underrun_clr ? {NUM_SRC{1'b0}} : r_underrun)
                    | (w_timeout ? w_sel : {NUM_SRC{1'b0}});
      r_overrun    <= (underrun_clr ? 1'b0 : r_overrun)
                    | (w_tick & (r_state != S_IDLE));
    end
  end

  assign req        = r_req;
  assign left       = r_left;
  assign right      = r_right;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;

endmodule
